// File: rtl/ysyx_23060184_pc_seq_pkg.sv
// Shared types and defaults for the fetch/commit sequencer.
// State encodings are fixed so waveforms and debug tooling can decode them.
package ysyx_23060184_pc_seq_pkg;

    localparam int          PC_SEQ_DATA_WIDTH = 32;
    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h8000_0000;

    typedef enum logic [2:0] {
        PC_SEQ_FETCH  = 3'd0,
        PC_SEQ_WAIT   = 3'd1,
        PC_SEQ_EXEC   = 3'd2,
        PC_SEQ_COMMIT = 3'd3,
        PC_SEQ_HALT   = 3'd4,
        PC_SEQ_FAULT  = 3'd5
    } pc_seq_state_e;

    // Instructions are word aligned; any set low bit is a bad target.
    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_23060184_instret_cnt.sv
// Retired-instruction counter, wraps modulo 2^DATA_WIDTH.
// Latency: count updates on the edge after inc; reset beats inc.
// Backpressure: none, pure counter.
module ysyx_23060184_instret_cnt #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc,
    output logic [DATA_WIDTH-1:0] count
);

    localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/ysyx_23060184_pc_seq.sv
// Fetch/commit sequencer: owns the PC and walks one instruction through fetch, exec, commit.
// Latency: 4 cycles per instruction minimum (FETCH, WAIT, EXEC, COMMIT).
// Backpressure: each state holds until its handshake input is high; HALT/FAULT hold until reset.
module ysyx_23060184_pc_seq
    import ysyx_23060184_pc_seq_pkg::*;
#(
    parameter int                    DATA_WIDTH = PC_SEQ_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  ifu_req_valid,
    input  logic                  ifu_req_ready,
    output logic [DATA_WIDTH-1:0] ifu_req_addr,
    input  logic                  ifu_resp_valid,
    output logic                  ifu_resp_ready,
    input  logic [DATA_WIDTH-1:0] ifu_resp_inst,
    input  logic                  ifu_resp_err,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] PC,
    output logic [DATA_WIDTH-1:0] Inst,
    input  logic                  commit_valid,
    input  logic [DATA_WIDTH-1:0] NPC,
    input  logic                  halt,
    output logic                  halted,
    output logic                  fault,
    output logic [DATA_WIDTH-1:0] fault_pc,
    output logic [DATA_WIDTH-1:0] instret
);

    pc_seq_state_e         state_q;
    pc_seq_state_e         state_d;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] inst_q;
    logic [DATA_WIDTH-1:0] fault_pc_q;
    logic                  fault_q;

    logic resp_ok;
    logic resp_bad;
    logic commit_fire;
    logic commit_halt;
    logic commit_bad;
    logic commit_ok;
    logic retire;

    assign resp_ok     = (state_q == PC_SEQ_WAIT) && ifu_resp_valid && !ifu_resp_err;
    assign resp_bad    = (state_q == PC_SEQ_WAIT) && ifu_resp_valid && ifu_resp_err;
    assign commit_fire = (state_q == PC_SEQ_COMMIT) && commit_valid;
    // Halt outranks the alignment check: an ebreak retires even with a bogus NPC.
    assign commit_halt = commit_fire && halt;
    assign commit_bad  = commit_fire && !halt && is_misaligned(NPC[1:0]);
    assign commit_ok   = commit_fire && !halt && !is_misaligned(NPC[1:0]);
    assign retire      = commit_halt || commit_ok;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PC_SEQ_FETCH:  if (ifu_req_ready) state_d = PC_SEQ_WAIT;
            PC_SEQ_WAIT: begin
                if (resp_ok)       state_d = PC_SEQ_EXEC;
                else if (resp_bad) state_d = PC_SEQ_FAULT;
            end
            PC_SEQ_EXEC:   if (inst_ready) state_d = PC_SEQ_COMMIT;
            PC_SEQ_COMMIT: begin
                if (commit_halt)     state_d = PC_SEQ_HALT;
                else if (commit_bad) state_d = PC_SEQ_FAULT;
                else if (commit_ok)  state_d = PC_SEQ_FETCH;
            end
            PC_SEQ_HALT:   state_d = PC_SEQ_HALT;
            PC_SEQ_FAULT:  state_d = PC_SEQ_FAULT;
            default:       state_d = PC_SEQ_FAULT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= PC_SEQ_FETCH;
            pc_q       <= RESET_PC;
            inst_q     <= '0;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= resp_bad || commit_bad;
            if (resp_ok) begin
                inst_q <= ifu_resp_inst;
            end
            if (commit_ok) begin
                pc_q <= NPC;
            end
            if (resp_bad) begin
                fault_pc_q <= pc_q;
            end else if (commit_bad) begin
                fault_pc_q <= NPC;
            end
        end
    end

    ysyx_23060184_instret_cnt #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_instret_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (retire),
        .count(instret)
    );

    // Handshakes come straight from the state register, no input feedthrough.
    assign ifu_req_valid  = (state_q == PC_SEQ_FETCH);
    assign ifu_resp_ready = (state_q == PC_SEQ_WAIT);
    assign inst_valid     = (state_q == PC_SEQ_EXEC);
    assign halted         = (state_q == PC_SEQ_HALT);
    assign ifu_req_addr   = pc_q;
    assign PC             = pc_q;
    assign Inst           = inst_q;
    assign fault          = fault_q;
    assign fault_pc       = fault_pc_q;

endmodule

// File: tb/tb_ysyx_23060184_pc_seq.sv
// Directed bench for the fetch/commit sequencer; drives and samples on the falling edge.
module tb_ysyx_23060184_pc_seq;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_req_addr;
    logic        ifu_resp_valid;
    logic        ifu_resp_ready;
    logic [31:0] ifu_resp_inst;
    logic        ifu_resp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] PC;
    logic [31:0] Inst;
    logic        commit_valid;
    logic [31:0] NPC;
    logic        halt;
    logic        halted;
    logic        fault;
    logic [31:0] fault_pc;
    logic [31:0] instret;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ysyx_23060184_pc_seq dut (
        .clk           (clk),
        .reset         (reset),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_req_addr  (ifu_req_addr),
        .ifu_resp_valid(ifu_resp_valid),
        .ifu_resp_ready(ifu_resp_ready),
        .ifu_resp_inst (ifu_resp_inst),
        .ifu_resp_err  (ifu_resp_err),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .PC            (PC),
        .Inst          (Inst),
        .commit_valid  (commit_valid),
        .NPC           (NPC),
        .halt          (halt),
        .halted        (halted),
        .fault         (fault),
        .fault_pc      (fault_pc),
        .instret       (instret)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_all(input logic v);
        ifu_req_ready  = v;
        ifu_resp_valid = v;
        inst_ready     = v;
        commit_valid   = v;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        set_all(1'b0);
        ifu_resp_err  = 1'b0;
        ifu_resp_inst = NOP;
        halt          = 1'b0;
        NPC           = 32'h0;
        steps(2);
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        do_reset();
        check("rst_req_valid", ifu_req_valid, 1);
        check("rst_req_addr", ifu_req_addr, 32'h8000_0000);
        check("rst_instret", instret, 0);
        check("rst_inst", Inst, 0);
        check("rst_fault", fault, 0);
        check("rst_halted", halted, 0);
        check("rst_fault_pc", fault_pc, 0);

        // Back-to-back commits
        set_all(1'b1);
        NPC = 32'h8000_0004;
        step();
        check("b2b_wait_resp_rdy", ifu_resp_ready, 1);
        check("b2b_wait_req_vld", ifu_req_valid, 0);
        step();
        check("b2b_exec_inst_vld", inst_valid, 1);
        check("b2b_exec_inst", Inst, NOP);
        step();
        check("b2b_commit_pc", PC, 32'h8000_0000);
        check("b2b_commit_inst_vld", inst_valid, 0);
        step();
        check("b2b_pc1", PC, 32'h8000_0004);
        check("b2b_instret1", instret, 1);
        check("b2b_req_vld1", ifu_req_valid, 1);
        NPC = 32'h8000_0008;
        steps(4);
        check("b2b_pc2", PC, 32'h8000_0008);
        check("b2b_instret2", instret, 2);

        // Request stall
        ifu_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_req_vld", ifu_req_valid, 1);
            check("stall_req_addr", ifu_req_addr, 32'h8000_0008);
        end
        ifu_req_ready  = 1'b1;
        ifu_resp_valid = 1'b0;
        step();
        // Response stall
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_wait_resp_rdy", ifu_resp_ready, 1);
            check("stall_wait_inst_vld", inst_valid, 0);
        end
        ifu_resp_valid = 1'b1;
        inst_ready     = 1'b0;
        step();
        // Execute stall
        for (int i = 0; i < 2; i++) begin
            step();
            check("stall_exec_vld", inst_valid, 1);
            check("stall_exec_inst", Inst, NOP);
            check("stall_exec_pc", PC, 32'h8000_0008);
        end
        inst_ready = 1'b1;
        NPC        = 32'h8000_0100;
        steps(2);
        check("jump_req_addr", ifu_req_addr, 32'h8000_0100);
        check("jump_req_vld", ifu_req_valid, 1);
        check("jump_instret", instret, 3);

        // Misaligned NPC
        NPC = 32'h8000_0102;
        steps(4);
        check("mis_fault", fault, 1);
        check("mis_fault_pc", fault_pc, 32'h8000_0102);
        check("mis_instret", instret, 3);
        check("mis_pc", PC, 32'h8000_0100);
        step();
        check("mis_fault_pulse", fault, 0);
        check("mis_no_req", ifu_req_valid, 0);

        // Fetch error at 0x80000008
        do_reset();
        set_all(1'b1);
        NPC = 32'h8000_0004;
        steps(4);
        NPC = 32'h8000_0008;
        steps(4);
        check("err_pc", PC, 32'h8000_0008);
        ifu_resp_err = 1'b1;
        step();
        check("err_wait", ifu_resp_ready, 1);
        step();
        check("err_fault", fault, 1);
        check("err_fault_pc", fault_pc, 32'h8000_0008);
        check("err_instret", instret, 2);
        check("err_inst_vld", inst_valid, 0);
        step();
        check("err_fault_pulse", fault, 0);
        check("err_no_req", ifu_req_valid, 0);
        steps(2);
        check("err_no_req_later", ifu_req_valid, 0);
        check("err_not_halted", halted, 0);

        // Halt
        do_reset();
        set_all(1'b1);
        halt = 1'b1;
        NPC  = 32'h8000_0004;
        steps(4);
        check("halt_halted", halted, 1);
        check("halt_instret", instret, 1);
        check("halt_pc", PC, 32'h8000_0000);
        check("halt_no_req", ifu_req_valid, 0);
        check("halt_no_fault", fault, 0);
        step();
        check("halt_sticky", halted, 1);

        // Reset in the same cycle as a commit
        reset = 1'b1;
        steps(2);
        reset = 1'b0;
        halt  = 1'b0;
        steps(4);
        check("pre_rst_pc", PC, 32'h8000_0004);
        check("pre_rst_instret", instret, 1);
        NPC = 32'h8000_0008;
        steps(3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rstpri_pc", PC, 32'h8000_0000);
        check("rstpri_instret", instret, 0);
        check("rstpri_req_vld", ifu_req_valid, 1);
        check("rstpri_halted", halted, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ysyx_23060184_pc_seq.md
# ysyx_23060184_pc_seq

Fetch/commit sequencer for the single-issue core. Owns the architectural PC register and drives one instruction at a time through fetch, execute, and commit. It issues a fetch request to instruction memory and hands the fetched instruction to decode/execute. It then waits for commit and loads the PC from the next-PC unit's `NPC` output. It also detects fetch errors and misaligned targets, handles the simulation halt, and counts retired instructions.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of PC, instruction, and counters.
- `RESET_PC`, 32'h8000_0000, PC value loaded on reset.

Ports:
- `clk`  in  1  core clock; everything updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ifu_req_valid`  out  1  fetch request valid.
- `ifu_req_ready`  in  1  memory accepts the request.
- `ifu_req_addr`  out  DATA_WIDTH  fetch address; always equal to `PC`.
- `ifu_resp_valid`  in  1  fetch response valid.
- `ifu_resp_ready`  out  1  sequencer accepts the response.
- `ifu_resp_inst`  in  DATA_WIDTH  fetched instruction word.
- `ifu_resp_err`  in  1  access fault on this response.
- `inst_valid`  out  1  `Inst`/`PC` valid for decode/execute.
- `inst_ready`  in  1  execute has taken the instruction.
- `PC`  out  DATA_WIDTH  current architectural PC.
- `Inst`  out  DATA_WIDTH  registered instruction.
- `commit_valid`  in  1  execute done; `NPC` is final.
- `NPC`  in  DATA_WIDTH  next PC from the next-PC unit.
- `halt`  in  1  ebreak retiring; sampled only with `commit_valid`.
- `halted`  out  1  sequencer stopped by `halt`.
- `fault`  out  1  one-cycle pulse on a fetch error or misaligned `NPC`.
- `fault_pc`  out  DATA_WIDTH  PC of the faulting fetch, or the offending `NPC`.
- `instret`  out  DATA_WIDTH  retired-instruction count.

## Operation
States: FETCH, WAIT, EXEC, COMMIT, HALT, FAULT.

- **FETCH**
  - `ifu_req_valid`=1.
  - When `ifu_req_ready` is high, go to WAIT.
- **WAIT**
  - `ifu_resp_ready`=1.
  - On `ifu_resp_valid` with `ifu_resp_err`=0: latch `Inst` and go to EXEC.
  - On `ifu_resp_valid` with `ifu_resp_err`=1: pulse `fault`, set `fault_pc`=`PC`, go to FAULT.
- **EXEC**
  - `inst_valid`=1.
  - When `inst_ready` is high, go to COMMIT.
- **COMMIT**
  - Wait for `commit_valid`. When it is high, evaluate in priority order:
    1. `halt`: `instret`+=1, PC unchanged, go to HALT.
    2. `NPC[1:0]`!=0: pulse `fault`, set `fault_pc`=`NPC`, PC unchanged, `instret` unchanged, go to FAULT.
    3. Otherwise: PC<=`NPC`, `instret`+=1, go to FETCH.
- **HALT / FAULT**
  - Terminal states; all handshake outputs are 0.
  - Only `reset` leaves them.
  - `halted`=1 only in HALT.
- **Ignored inputs**
  - `inst_ready` is ignored outside EXEC.
  - `commit_valid` is ignored outside COMMIT.
  - `ifu_resp_valid` is ignored outside WAIT.
- **Arithmetic**
  - `instret` wraps modulo 2^DATA_WIDTH.
  - PC is loaded only from `NPC`; no internal increment. PC+4 is the next-PC unit's job.

## Timing
- **Reset values:** state=FETCH, `PC`=`RESET_PC`, `Inst`=0, `instret`=0, `fault_pc`=0, `fault`=0, `halted`=0.
  - Consequence: `ifu_req_valid`=1 in the first cycle after `reset` deasserts.
- **Output timing**
  - Handshake outputs and `halted` are decoded combinationally from the state register only; no input-to-output combinational paths.
  - `fault` is registered and lasts exactly one cycle.
- **Minimum instruction latency:** 4 cycles (FETCH→WAIT→EXEC→COMMIT→FETCH), with `ifu_req_ready`, `ifu_resp_valid`, `inst_ready` and `commit_valid` all high.
- **Handshake rules**
  - `ifu_req_addr` stays stable while `ifu_req_valid` is high and `ifu_req_ready` is low.
  - `Inst` and `PC` stay stable throughout EXEC and COMMIT.
- **Single outstanding request:** a response is never accepted in the same cycle its request is accepted. At least one WAIT cycle always occurs.
- **Reset mid-operation**
  - Reset wins over every other event in the same cycle.
  - The memory shares `reset`, so no stale response survives.
  - The `instret` increment of a commit in the same cycle as reset is dropped.

## Structure
- Put the state encodings (3-bit) as `define` constants in the shared defines header, next to the `NPC_OP_*` codes.
  - `PC_SEQ_FETCH`=0, `PC_SEQ_WAIT`=1, `PC_SEQ_EXEC`=2, `PC_SEQ_COMMIT`=3, `PC_SEQ_HALT`=4, `PC_SEQ_FAULT`=5.
- Add `RESET_PC` to the same header as the default.
- One sub-module is natural: `ysyx_23060184_instret_cnt`, a DATA_WIDTH counter with synchronous reset and an increment enable. Everything else stays in one always block plus output decode.

## Test plan
- **Reset:** hold `reset` for 2 cycles, release. Expect `ifu_req_valid`=1, `ifu_req_addr`=32'h8000_0000, `instret`=0.
- **Back-to-back commits:** all ready/valid inputs tied high, `NPC`=PC+4. Expect PC=0x80000000, 0x80000004, 0x80000008 at 4-cycle spacing, and `instret`=2 after the second commit.
- **Stalls:**
  - Hold `ifu_req_ready` low for 3 cycles: `ifu_req_addr` stays stable.
  - Hold `ifu_resp_valid` low for 5 cycles: stays in WAIT.
  - Hold `inst_ready` low for 2 cycles: `Inst`=32'h00000013 stays stable.
- **Jump:** commit with `NPC`=32'h8000_0100. The next `ifu_req_addr` is 0x80000100.
- **Fault paths**
  - Response with `ifu_resp_err`=1 at PC 0x80000008: `fault` high for 1 cycle, `fault_pc`=0x80000008, no further requests.
  - Separately, `NPC`=0x80000102: `fault_pc`=0x80000102, `instret` unchanged.
- **Halt and reset priority**
  - Commit with `halt`=1: `halted`=1, `instret`+1, PC unchanged.
  - Then assert `reset` in the same cycle as `commit_valid`: PC=`RESET_PC`, `instret`=0, state=FETCH.
